// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store initiator.
//   - funct3 size/sign codes (RV32 encoding)
//   - lsu_state_t FSM state encoding
//   - f3_legal(): legality of a funct3 code for a load or a store
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Stores have no unsigned variants; loads accept all five size codes.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_master_ext.sv
// lsu_ext: combinational load extender.
//   funct3 : load size/sign code
//   word   : little-endian word sampled from memory (byte 0 in [7:0])
//   result : byte/half sign- or zero-extended, or the full word
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = signed'(word[7:0]);
    half_s = signed'(word[15:0]);
    result = word;
    case (funct3)
      F3_B:    result = 32'(byte_s);
      F3_BU:   result = {24'd0, word[7:0]};
      F3_H:    result = 32'(half_s);
      F3_HU:   result = {16'd0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: single-outstanding load/store initiator for a byte-addressed
// unified memory. A request is latched in IDLE, held on the registered mem_*
// port for MEM_LAT+1 cycles (ACCESS), then returned on a valid/ready
// response (RESP). Loads are extended by lsu_ext from the sampled word.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_store, req_funct3,
//   req_addr, req_wdata              request payload
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             extended load data / error flag
//   mem_rw, mem_addr, mem_wdata,
//   mem_funct3, mem_rdata            memory port (all outputs registered)
//
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// requests are rejected with resp_err instead of being issued.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state;
  logic [3:0]  cnt;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] ext_word;
  logic        req_bad;

  // Memory wraps inside its own address space; upper bits are don't-care.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  always_comb begin
    req_bad = !f3_legal(req_store, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
`endif
  end

  // f3_q keeps the full code (incl. unsigned bit) for extension.
  lsu_ext u_ext (
    .funct3 (f3_q),
    .word   (mem_rdata),
    .result (ext_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      f3_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            f3_q       <= req_funct3;
            mem_addr   <= req_addr[ADDR_W-1:0];
            mem_wdata  <= req_wdata;
            mem_funct3 <= {1'b0, req_funct3[1:0]};
            req_ready  <= 1'b0;
            if (req_bad) begin
              // Rejected without touching memory; mem_rw stays low.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ACCESS;
              cnt      <= 4'(MEM_LAT);
              mem_rw   <= req_store;
              resp_err <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last access cycle: drop the write strobe with the state change
            // and capture the read word while the address is still driven.
            state      <= RESP;
            mem_rw     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= store_q ? 32'd0 : ext_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          mem_rw     <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed table-driven bench for lsu_master.
// u_dut0 runs with MEM_LAT=0 for the functional vectors and reset case;
// u_dut1 runs with MEM_LAT=3 for the wait-state and back-pressure case.
// Each DUT has a small byte-array memory initialised to mem[i]=i.
module tb_lsu_master;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT0 (MEM_LAT=0) ----------------
  logic              req_valid0 = 1'b0, req_ready0, req_store0 = 1'b0;
  logic [2:0]        req_funct3_0 = '0;
  logic [31:0]       req_addr0 = '0, req_wdata0 = '0;
  logic              resp_valid0, resp_ready0 = 1'b0, resp_err0;
  logic [31:0]       resp_rdata0;
  logic              mem_rw0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [31:0]       mem_wdata0, mem_rdata0;
  logic [2:0]        mem_funct3_0;

  lsu_master #(.ADDR_W(ADDR_W), .MEM_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_store(req_store0),
    .req_funct3(req_funct3_0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_rw(mem_rw0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_funct3(mem_funct3_0), .mem_rdata(mem_rdata0)
  );

  // ---------------- DUT1 (MEM_LAT=3) ----------------
  logic              req_valid1 = 1'b0, req_ready1, req_store1 = 1'b0;
  logic [2:0]        req_funct3_1 = '0;
  logic [31:0]       req_addr1 = '0, req_wdata1 = '0;
  logic              resp_valid1, resp_ready1 = 1'b0, resp_err1;
  logic [31:0]       resp_rdata1;
  logic              mem_rw1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [31:0]       mem_wdata1, mem_rdata1;
  logic [2:0]        mem_funct3_1;

  lsu_master #(.ADDR_W(ADDR_W), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_store(req_store1),
    .req_funct3(req_funct3_1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_rw(mem_rw1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_funct3(mem_funct3_1), .mem_rdata(mem_rdata1)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 8'(i);
    end else if (mem_rw0) begin
      mem0[mem_addr0] <= mem_wdata0[7:0];
      if (mem_funct3_0 != 3'b000) mem0[mem_addr0 + 8'd1] <= mem_wdata0[15:8];
      if (mem_funct3_0 == 3'b010) begin
        mem0[mem_addr0 + 8'd2] <= mem_wdata0[23:16];
        mem0[mem_addr0 + 8'd3] <= mem_wdata0[31:24];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 8'(i);
    end else if (mem_rw1) begin
      mem1[mem_addr1] <= mem_wdata1[7:0];
      if (mem_funct3_1 != 3'b000) mem1[mem_addr1 + 8'd1] <= mem_wdata1[15:8];
      if (mem_funct3_1 == 3'b010) begin
        mem1[mem_addr1 + 8'd2] <= mem_wdata1[23:16];
        mem1[mem_addr1 + 8'd3] <= mem_wdata1[31:24];
      end
    end
  end

  assign mem_rdata0 = {mem0[mem_addr0 + 8'd3], mem0[mem_addr0 + 8'd2],
                       mem0[mem_addr0 + 8'd1], mem0[mem_addr0]};
  assign mem_rdata1 = {mem1[mem_addr1 + 8'd3], mem1[mem_addr1 + 8'd2],
                       mem1[mem_addr1 + 8'd1], mem1[mem_addr1]};

  // Write-strobe monitors: free-running counts of cycles with mem_rw high.
  int         wr_total0 = 0, wr_total1 = 0;
  logic [7:0] last_waddr0 = '0;
  logic [2:0] last_wf3_0 = '0;
  always @(negedge clk) begin
    if (mem_rw0) begin
      wr_total0   = wr_total0 + 1;
      last_waddr0 = mem_addr0;
      last_wf3_0  = mem_funct3_0;
    end
    if (mem_rw1) wr_total1 = wr_total1 + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [7:0]  exp_waddr;
    logic [2:0]  exp_wf3;
  } vec_t;

  vec_t vecs[16];

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int wr_before;
    @(negedge clk);
    wr_before    = wr_total0;
    req_valid0   = 1'b1;
    req_store0   = v.store;
    req_funct3_0 = v.f3;
    req_addr0    = v.addr;
    req_wdata0   = v.wdata;
    resp_ready0  = 1'b0;
    check($sformatf("v%0d_req_ready", idx), 32'(req_ready0), 32'd1);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 1;
    while (!resp_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), resp_rdata0, v.exp_rdata);
    check($sformatf("v%0d_err", idx), 32'(resp_err0), 32'(v.exp_err));
    check($sformatf("v%0d_wr_cycles", idx), 32'(wr_total0 - wr_before), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      check($sformatf("v%0d_waddr", idx), 32'(last_waddr0), 32'(v.exp_waddr));
      check($sformatf("v%0d_wf3", idx), 32'(last_wf3_0), 32'(v.exp_wf3));
    end
    @(negedge clk);
    resp_ready0 = 1'b1;
    @(posedge clk); #1;
    resp_ready0 = 1'b0;
    check($sformatf("v%0d_resp_drop", idx), 32'(resp_valid0), 32'd0);
  endtask

  initial begin
    int   lat;
    int   wr_before;
    logic ok;
    logic hold_ok;

    //            store f3      addr          wdata         rdata         err lat wr waddr  wf3
    vecs[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 8'h10, 3'b010};
    vecs[1]  = '{1'b0, 3'b000, 32'h10,       32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[2]  = '{1'b0, 3'b100, 32'h10,       32'h0,        32'h000000EF, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[3]  = '{1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[4]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[5]  = '{1'b1, 3'b011, 32'h10,       32'h11111111, 32'h0,        1'b1, 1, 0, 8'h00, 3'b000};
    vecs[6]  = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, 8'h00, 3'b000};
    vecs[7]  = '{1'b0, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, 8'h00, 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8]  = '{1'b0, 3'b010, 32'h11,       32'h0,        32'h0,        1'b1, 1, 0, 8'h00, 3'b000};
`else
    vecs[8]  = '{1'b0, 3'b010, 32'h11,       32'h0,        32'h14DEADBE, 1'b0, 2, 0, 8'h00, 3'b000};
`endif
    vecs[9]  = '{1'b1, 3'b000, 32'h20,       32'h12345680, 32'h0,        1'b0, 2, 1, 8'h20, 3'b000};
    vecs[10] = '{1'b0, 3'b000, 32'h20,       32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[11] = '{1'b0, 3'b101, 32'h20,       32'h0,        32'h00002180, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[12] = '{1'b1, 3'b001, 32'h00100032, 32'h0000A5C3, 32'h0,        1'b0, 2, 1, 8'h32, 3'b001};
    vecs[13] = '{1'b0, 3'b001, 32'h32,       32'h0,        32'hFFFFA5C3, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[14] = '{1'b0, 3'b010, 32'hFC,       32'h0,        32'hFFFEFDFC, 1'b0, 2, 0, 8'h00, 3'b000};
    vecs[15] = '{1'b1, 3'b100, 32'h40,       32'h22222222, 32'h0,        1'b1, 1, 0, 8'h00, 3'b000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready0), 32'd1);
    check("rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("rst_resp_rdata", resp_rdata0, 32'd0);
    check("rst_resp_err", 32'(resp_err0), 32'd0);
    check("rst_mem_rw", 32'(mem_rw0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_mem_wdata", mem_wdata0, 32'd0);
    check("rst_mem_funct3", 32'(mem_funct3_0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Functional vectors on MEM_LAT=0
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Wait states and back-pressure on MEM_LAT=3: LHU 0x40 -> 0x4140
    @(negedge clk);
    req_valid1   = 1'b1;
    req_store1   = 1'b0;
    req_funct3_1 = 3'b101;
    req_addr1    = 32'h40;
    resp_ready1  = 1'b0;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    ok  = 1'b1;
    lat = 1;
    while (!resp_valid1 && lat < 20) begin
      if (mem_addr1 !== 8'h40 || mem_rw1 !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("ws_latency", 32'(lat), 32'd5);
    check("ws_addr_stable", 32'(ok), 32'd1);
    check("ws_rdata", resp_rdata1, 32'h00004140);
    // Hold resp_ready low with a competing store request presented.
    wr_before    = wr_total1;
    req_valid1   = 1'b1;
    req_store1   = 1'b1;
    req_funct3_1 = 3'b010;
    req_addr1    = 32'h50;
    req_wdata1   = 32'hCAFEF00D;
    hold_ok      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (resp_valid1 !== 1'b1 || resp_rdata1 !== 32'h00004140 ||
          resp_err1 !== 1'b0 || req_ready1 !== 1'b0) hold_ok = 1'b0;
    end
    check("ws_hold", 32'(hold_ok), 32'd1);
    check("ws_ignored_req_wr", 32'(wr_total1 - wr_before), 32'd0);
    @(negedge clk);
    req_valid1  = 1'b0;
    resp_ready1 = 1'b1;
    @(posedge clk); #1;
    resp_ready1 = 1'b0;
    check("ws_req_ready_back", 32'(req_ready1), 32'd1);
    check("ws_resp_drop", 32'(resp_valid1), 32'd0);

    // Store on MEM_LAT=3 keeps the strobe for 4 cycles
    @(negedge clk);
    wr_before    = wr_total1;
    req_valid1   = 1'b1;
    req_store1   = 1'b1;
    req_funct3_1 = 3'b010;
    req_addr1    = 32'h60;
    req_wdata1   = 32'h01020304;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    lat = 1;
    while (!resp_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ws_store_latency", 32'(lat), 32'd5);
    check("ws_store_wr_cycles", 32'(wr_total1 - wr_before), 32'd4);
    check("ws_store_rdata", resp_rdata1, 32'd0);
    @(negedge clk);
    resp_ready1 = 1'b1;
    @(posedge clk); #1;
    resp_ready1 = 1'b0;

    // Asynchronous reset in the middle of a store access
    @(negedge clk);
    req_valid0   = 1'b1;
    req_store0   = 1'b1;
    req_funct3_0 = 3'b010;
    req_addr0    = 32'h70;
    req_wdata0   = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("arst_mem_rw_before", 32'(mem_rw0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_rw_drop", 32'(mem_rw0), 32'd0);
    check("arst_resp_valid", 32'(resp_valid0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1 || mem_rw0 !== 1'b0) ok = 1'b0;
    end
    check("arst_idle_after", 32'(ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
